// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line renderer: OAM word layout,
// sprite-list entry format, row geometry and the render FSM states.
package sprite_pkg;

    localparam int OAM_ADDR_W = 6;

    localparam int OAM_EN_BIT    = 31;
    localparam int OAM_YFLIP_BIT = 30;
    localparam int OAM_XFLIP_BIT = 29;
    localparam int OAM_PRIO_BIT  = 28;
    localparam int OAM_YPOS_LSB  = 18;
    localparam int OAM_XPOS_LSB  = 8;
    localparam int OAM_REF_LSB   = 0;

    localparam int SPRITE_ROWS    = 16;
    localparam int PIXELS_PER_ROW = 16;
    localparam logic [3:0] TRANSPARENT = 4'd0;

    typedef struct packed {
        logic       en;
        logic       yflip;
        logic       xflip;
        logic       prio;
        logic [9:0] ypos;
        logic [9:0] xpos;
        logic [7:0] spr_ref;
    } oam_entry_t;

    typedef struct packed {
        logic [OAM_ADDR_W-1:0] oam_idx;
        logic                  en;
    } list_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_OAM_CAP,
        ST_ROW_REQ,
        ST_ROW_CAP,
        ST_DRAW,
        ST_DONE
    } render_state_t;

    function automatic logic [3:0] row_pixel(input logic [63:0] row, input logic [3:0] idx);
        return row[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sprite_row_writer.sv
// Serialises one captured 16-pixel sprite row into line-buffer writes,
// applying x-flip, transparency and right-edge clipping; outputs registered.
module sprite_row_writer
    import sprite_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        draw_en,
    input  logic [3:0]  p,
    input  logic [63:0] row,
    input  logic [9:0]  xpos,
    input  logic        xflip,
    input  logic        prio,
    output logic        lb_we,
    output logic [9:0]  lb_x,
    output logic [3:0]  lb_color,
    output logic        lb_priority
);

    logic [3:0]  src_p0;
    logic [3:0]  pix_p0;
    logic [10:0] x_p0;
    logic        we_p0;

    // Eleven-bit X so sprites hanging off the right edge clip instead of wrapping.
    always_comb begin
        src_p0 = xflip ? 4'(PIXELS_PER_ROW - 1) - p : p;
        pix_p0 = row_pixel(row, src_p0);
        x_p0   = {1'b0, xpos} + {7'd0, p};
        we_p0  = draw_en && (pix_p0 != TRANSPARENT) && (x_p0 < 11'(H_ACTIVE));
    end

    // p0 -> p1: registered line-buffer write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lb_we       <= 1'b0;
            lb_x        <= '0;
            lb_color    <= '0;
            lb_priority <= 1'b0;
        end else begin
            lb_we <= we_p0;
            if (we_p0) begin
                lb_x        <= x_p0[9:0];
                lb_color    <= pix_p0;
                lb_priority <= prio;
            end
        end
    end

endmodule

// File: rtl/sprite_line_renderer.sv
// Walks the snapshotted per-line sprite list from the highest entry down,
// fetches OAM and one pixel row per visible sprite and draws it into the line buffer.
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int MAX_OBJECTS_PER_LINE = 32,
    parameter int OAM_ADDR_SIZE        = OAM_ADDR_W,
    parameter int H_ACTIVE             = 640
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [MAX_OBJECTS_PER_LINE*(OAM_ADDR_SIZE+1)-1:0] buffer_array,
    input  logic                                          line_prepared,
    input  logic [9:0]                                    sy,
    output logic [OAM_ADDR_SIZE-1:0]                      oam_addr,
    input  logic [31:0]                                   oam_data,
    output logic [11:0]                                   sprite_addr,
    input  logic [63:0]                                   sprite_data,
    output logic                                          lb_we,
    output logic [9:0]                                    lb_x,
    output logic [3:0]                                    lb_color,
    output logic                                          lb_priority,
    output logic                                          busy,
    output logic                                          line_done
);

    localparam int IDX_W = $clog2(MAX_OBJECTS_PER_LINE);

    render_state_t    state;
    logic [IDX_W-1:0] idx;
    list_entry_t      list_snap [MAX_OBJECTS_PER_LINE];
    logic [9:0]       sy_snap;
    logic             lp_prev;
    logic [9:0]       xpos_q;
    logic             xflip_q;
    logic             prio_q;
    logic [63:0]      row_q;
    logic [3:0]       p;

    oam_entry_t oam_in;
    logic [9:0] row_raw;
    logic       entry_hit;
    logic       start;
    logic       abort;
    logic       last_entry;
    logic       draw_en;

    always_comb begin
        oam_in         = '0;
        oam_in.en      = oam_data[OAM_EN_BIT];
        oam_in.yflip   = oam_data[OAM_YFLIP_BIT];
        oam_in.xflip   = oam_data[OAM_XFLIP_BIT];
        oam_in.prio    = oam_data[OAM_PRIO_BIT];
        oam_in.ypos    = oam_data[OAM_YPOS_LSB +: 10];
        oam_in.xpos    = oam_data[OAM_XPOS_LSB +: 10];
        oam_in.spr_ref = oam_data[OAM_REF_LSB +: 8];
    end

    // Modulo-1024 row: sprites above the line wrap to large values and are skipped.
    assign row_raw    = sy_snap - oam_in.ypos;
    assign entry_hit  = oam_in.en && (row_raw < 10'(SPRITE_ROWS));
    assign start      = line_prepared && !lp_prev && (state == ST_IDLE);
    assign abort      = (state != ST_IDLE) && (!line_prepared || (sy != sy_snap));
    assign last_entry = (idx == '0);
    assign draw_en    = (state == ST_DRAW) && !abort;
    assign oam_addr   = list_snap[idx].oam_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            sy_snap     <= '0;
            lp_prev     <= 1'b1;
            for (int i = 0; i < MAX_OBJECTS_PER_LINE; i++) list_snap[i] <= '0;
            xpos_q      <= '0;
            xflip_q     <= 1'b0;
            prio_q      <= 1'b0;
            row_q       <= '0;
            p           <= '0;
            sprite_addr <= '0;
            busy        <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            lp_prev   <= line_prepared;
            line_done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            for (int i = 0; i < MAX_OBJECTS_PER_LINE; i++)
                                list_snap[i] <= list_entry_t'(buffer_array[i*(OAM_ADDR_SIZE+1) +: (OAM_ADDR_SIZE+1)]);
                            sy_snap <= sy;
                            idx     <= IDX_W'(MAX_OBJECTS_PER_LINE - 1);
                            state   <= ST_SCAN;
                            busy    <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        if (list_snap[idx].en) begin
                            state <= ST_OAM_CAP;
                        end else if (last_entry) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                    ST_OAM_CAP: begin
                        xpos_q  <= oam_in.xpos;
                        xflip_q <= oam_in.xflip;
                        prio_q  <= oam_in.prio;
                        if (entry_hit) begin
                            sprite_addr <= {oam_in.spr_ref,
                                            oam_in.yflip ? 4'(SPRITE_ROWS - 1) - row_raw[3:0] : row_raw[3:0]};
                            state       <= ST_ROW_REQ;
                        end else if (last_entry) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                    ST_ROW_REQ: state <= ST_ROW_CAP;
                    ST_ROW_CAP: begin
                        row_q <= sprite_data;
                        p     <= '0;
                        state <= ST_DRAW;
                    end
                    ST_DRAW: begin
                        p <= p + 1'b1;
                        if (p == 4'(PIXELS_PER_ROW - 1)) begin
                            if (last_entry) begin
                                state <= ST_DONE;
                            end else begin
                                idx   <= idx - 1'b1;
                                state <= ST_SCAN;
                            end
                        end
                    end
                    ST_DONE: begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        line_done <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    sprite_row_writer #(
        .H_ACTIVE(H_ACTIVE)
    ) u_row_writer (
        .clk        (clk),
        .reset_n    (reset_n),
        .draw_en    (draw_en),
        .p          (p),
        .row        (row_q),
        .xpos       (xpos_q),
        .xflip      (xflip_q),
        .prio       (prio_q),
        .lb_we      (lb_we),
        .lb_x       (lb_x),
        .lb_color   (lb_color),
        .lb_priority(lb_priority)
    );

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Consumes the per-line sprite list built by the line-preparation stage and draws those sprites into the scanline pixel buffer. For each list entry it re-reads the OAM word, fetches one 16-pixel row from sprite pixel memory, and writes the opaque pixels at their screen X positions. It sits between the sprite-list builder and the line buffer read by the video output.

## Interface
- MAX_OBJECTS_PER_LINE, 32, number of sprite-list entries.
- OAM_ADDR_SIZE, 6, OAM word address width.
- H_ACTIVE, 640, visible pixels per line; writes at X ≥ H_ACTIVE are suppressed.

- clk  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- buffer_array  in  MAX_OBJECTS_PER_LINE×(OAM_ADDR_SIZE+1)  list entries, each {oam index, enable}; enable is bit 0.
- line_prepared  in  1  list is complete for the current sy.
- sy  in  10  current scanline.
- oam_addr  out  OAM_ADDR_SIZE  OAM read address.
- oam_data  in  32  OAM word; valid 1 cycle after oam_addr is driven.
- sprite_addr  out  12  sprite pixel-row address {spriteref[7:0], row[3:0]}.
- sprite_data  in  64  16 pixels × 4 bits; pixel i is at [4i+3:4i]. Valid 1 cycle after sprite_addr is driven.
- lb_we  out  1  line-buffer write strobe.
- lb_x  out  10  line-buffer X address.
- lb_color  out  4  palette index (never 0 when lb_we=1).
- lb_priority  out  1  sprite priority bit, passed through.
- busy  out  1  render in progress.
- line_done  out  1  one-cycle pulse when a line render completes.

## Operation
- OAM word layout:
  - [31] enable, [30] y-flip, [29] x-flip, [28] priority.
  - [27:18] ypos, [17:8] xpos, [7:0] spriteref.
- **Start:** rising edge of line_prepared (registered previous value 0, current 1) while the block is IDLE.
  - On start, buffer_array and sy are snapshotted. The upstream stage clears its list when sy changes.
- **Scan order:** entries are visited from index MAX_OBJECTS_PER_LINE-1 down to 0.
  - The lower index is written last, so the lower OAM index wins on overlap.
- **FSM states:**
  - IDLE: wait for start.
  - SCAN: if the entry's enable=1, drive oam_addr = entry index and go to OAM_CAP. Otherwise, if index=0 go to DONE, else decrement the index and stay in SCAN.
  - OAM_CAP: register the OAM fields and compute row = sy_snap − ypos (10-bit). If row ≥ 16 or OAM enable=0, skip the entry (same exit as a disabled entry). Otherwise apply y-flip (row = 15 − row) and go to ROW_REQ.
  - ROW_REQ: drive sprite_addr and go to ROW_CAP.
  - ROW_CAP: register the 64-bit row, clear the pixel counter p, and go to DRAW.
  - DRAW: 16 cycles, p = 0..15.
    - Pixel source index = x-flip ? 15−p : p.
    - X = xpos + p, computed with 11-bit arithmetic.
    - lb_we=1 only if the pixel ≠ 0 and X < H_ACTIVE.
    - After p=15: if index=0 go to DONE, else decrement and go to SCAN.
  - DONE: pulse line_done, return to IDLE.
- **Abort:** if line_prepared falls, or sy ≠ sy_snap, in any non-IDLE state:
  - Go to IDLE next cycle, with lb_we=0 from that cycle on.
  - No line_done pulse.
  - A new start requires a fresh rising edge of line_prepared.
- A start edge that arrives while the block is busy is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, snapshot registers 0.
  - Previous-line_prepared register reset to 1, so a level that is already high after reset does not start a render.
- Per-entry cost:
  - Disabled entry: 1 cycle.
  - Skipped entry (OAM disabled or row out of range): 2 cycles.
  - Drawn entry: 20 cycles (SCAN, OAM_CAP, ROW_REQ, ROW_CAP, 16×DRAW).
- Worst case: 32 drawn sprites = 640 cycles + 1 DONE cycle.
- busy is high from the cycle after the start edge through the DONE cycle.
- Pixel outputs (lb_*) are registered: the write for pixel p appears 1 cycle after DRAW cycle p.
- line_done is asserted 1 cycle after the final pixel write.
- Empty list: line_done is asserted 33 cycles after the start edge.

## Structure
- Shared package `sprite_pkg`:
  - OAM field bit positions.
  - oam_entry_t packed struct.
  - List-entry typedef.
  - SPRITE_ROWS=16, PIXELS_PER_ROW=16, TRANSPARENT=4'd0.
  - The FSM state enum.
- Sub-module `sprite_row_writer`: serialises one registered 64-bit row with flip, transparency and X-clip into the lb_* strobes.

## Test plan
- Empty list (all entry enables 0), line_prepared 0→1 → no lb_we; line_done 33 cycles after the edge.
- One entry, OAM index 5 = {en=1, yflip=0, xflip=0, prio=1, ypos=100, xpos=200, ref=3}, sy=104, row data 0x0123456789ABCDEF:
  - sprite_addr = 0x034.
  - 15 writes at X=200..214 with colours F,E,…,1, lb_priority=1.
  - X=215 (pixel 15 = 0) is not written.
- Same entry with xflip=1 and yflip=1 → sprite_addr = 0x03B; X=201..215 receive colours 1..F.
- xpos=630 → writes only for X=630..639; nothing at X ≥ 640.
- Two overlapping sprites at OAM indices 2 and 7, same xpos → index 7 is written first, index 2 last.
- sy changes while in DRAW → lb_we low from the next cycle, no line_done, IDLE within 1 cycle.
- reset_n asserted mid-DRAW → all outputs 0 immediately (asynchronous).
